// File: rtl/id_tracker.sv
// id_tracker -- in-order instruction-ID allocator.
//
// Hands out instruction IDs in circular order at issue time and reports the
// oldest in-flight ID so results can retire to the register file in order.
// IDs are freed strictly in the order they were allocated.
//
// Parameters:
//   MAX_INFLIGHT_COUNT  number of IDs (power of two, >= 2)
//   ID_W                ID width, $clog2(MAX_INFLIGHT_COUNT)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset, discards all in-flight IDs
//   issued        an instruction takes next_id this cycle
//   retired       the instruction holding oldest_id retires this cycle
//   id_available  at least one ID is free (issue is legal)
//   oldest_id     oldest in-flight ID (head)
//   next_id       ID handed to the next issued instruction (tail)
//   empty         no IDs in flight
//
// Optional build macro:
//   ID_TRACKER_ASSERT_EN  compiles in simulation-only overflow/underflow and
//                         pointer/count consistency checks. Functional
//                         behaviour is identical with or without it.

module id_tracker #(
  parameter int MAX_INFLIGHT_COUNT = 4,
  parameter int ID_W = $clog2(MAX_INFLIGHT_COUNT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issued,
  input  logic            retired,
  output logic            id_available,
  output logic [ID_W-1:0] oldest_id,
  output logic [ID_W-1:0] next_id,
  output logic            empty
);

  localparam logic [ID_W:0] MAX_COUNT = (ID_W + 1)'(MAX_INFLIGHT_COUNT);

  logic [ID_W-1:0] next_id_reg, next_id_next;
  logic [ID_W-1:0] oldest_id_reg, oldest_id_next;
  logic [ID_W:0]   count_reg, count_next;
  logic            issue_eff;
  logic            retire_eff;

  // Status flags come only from registered state, so there is no
  // combinational path from issued/retired to any output.
  assign id_available = (count_reg != MAX_COUNT);
  assign empty        = (count_reg == '0);
  assign next_id      = next_id_reg;
  assign oldest_id    = oldest_id_reg;

  always_comb begin
    // An issue while full is dropped.
    issue_eff  = issued & id_available;
    // A retire while empty is dropped unless it pairs with an issue in the
    // same cycle: a single-cycle unit may complete the ID it was just given.
    retire_eff = retired & (~empty | issued);

    // Pointers are exactly ID_W bits wide and the ID count is a power of
    // two, so natural overflow implements the modulo wrap.
    next_id_next   = next_id_reg + ID_W'(issue_eff);
    oldest_id_next = oldest_id_reg + ID_W'(retire_eff);
    count_next     = count_reg + (ID_W + 1)'(issue_eff) - (ID_W + 1)'(retire_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_id_reg   <= '0;
      oldest_id_reg <= '0;
      count_reg     <= '0;
    end else begin
      next_id_reg   <= next_id_next;
      oldest_id_reg <= oldest_id_next;
      count_reg     <= count_next;
    end
  end

`ifdef ID_TRACKER_ASSERT_EN
  // Simulation-only sanity checks on the caller's protocol and on the
  // internal pointer/count relationship.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(issued && !id_available))
        else $error("id_tracker: issue while no ID is available (overflow)");
      assert (!(retired && empty && !issued))
        else $error("id_tracker: retire while nothing is in flight (underflow)");
      assert ((next_id_reg - oldest_id_reg) == count_reg[ID_W-1:0])
        else $error("id_tracker: pointer distance disagrees with in-flight count");
      assert (count_reg <= MAX_COUNT)
        else $error("id_tracker: in-flight count exceeds MAX_INFLIGHT_COUNT");
    end
  end
`endif

endmodule

// File: tb/tb_id_tracker.sv
// Testbench for id_tracker with MAX_INFLIGHT_COUNT = 4.
// Directed table of {inputs, expected outputs} records, a hand-written
// issue+retire streaming sequence, then randomized traffic compared against
// a counter/pointer model built directly from the allocation rules.

module tb_id_tracker;

  localparam int MAX  = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            issued;
  logic            retired;
  logic            id_available;
  logic [ID_W-1:0] oldest_id;
  logic [ID_W-1:0] next_id;
  logic            empty;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: plain integers.
  int m_next   = 0;
  int m_oldest = 0;
  int m_count  = 0;

  always #5 clk = ~clk;

  id_tracker #(.MAX_INFLIGHT_COUNT(MAX), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .issued       (issued),
    .retired      (retired),
    .id_available (id_available),
    .oldest_id    (oldest_id),
    .next_id      (next_id),
    .empty        (empty)
  );

  typedef struct {
    logic rst;
    logic iss;
    logic ret;
    int   exp_next;
    int   exp_oldest;
    logic exp_empty;
    logic exp_avail;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample outputs 1 time unit after the edge.
  task automatic step(input logic r, input logic i, input logic t);
    rst     = r;
    issued  = i;
    retired = t;
    @(posedge clk);
    #1;
  endtask

  // Model of the allocation rules, evaluated once per clock edge.
  task automatic model_step(input logic r, input logic i, input logic t);
    int ie, re;
    if (r) begin
      m_next = 0; m_oldest = 0; m_count = 0;
    end else begin
      ie = (i && m_count < MAX) ? 1 : 0;
      re = (t && (m_count > 0 || i)) ? 1 : 0;
      m_next   = (m_next + ie) % MAX;
      m_oldest = (m_oldest + re) % MAX;
      m_count  = m_count + ie - re;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".next_id"},      int'(next_id),      m_next);
    chk({tag, ".oldest_id"},    int'(oldest_id),    m_oldest);
    chk({tag, ".empty"},        int'(empty),        (m_count == 0) ? 1 : 0);
    chk({tag, ".id_available"}, int'(id_available), (m_count != MAX) ? 1 : 0);
  endtask

  initial begin
    // rst iss ret | next oldest empty avail
    vecs[0]  = '{1, 0, 0, 0, 0, 1, 1};  // reset
    vecs[1]  = '{0, 0, 0, 0, 0, 1, 1};  // idle
    vecs[2]  = '{0, 1, 0, 1, 0, 0, 1};  // four issues
    vecs[3]  = '{0, 1, 0, 2, 0, 0, 1};
    vecs[4]  = '{0, 1, 0, 3, 0, 0, 1};
    vecs[5]  = '{0, 1, 0, 0, 0, 0, 0};  // full
    vecs[6]  = '{0, 1, 0, 0, 0, 0, 0};  // 5th issue ignored
    vecs[7]  = '{0, 0, 1, 0, 1, 0, 1};  // drain by retire
    vecs[8]  = '{0, 0, 1, 0, 2, 0, 1};
    vecs[9]  = '{0, 0, 1, 0, 3, 0, 1};
    vecs[10] = '{0, 0, 1, 0, 0, 1, 1};  // empty again
    vecs[11] = '{0, 1, 1, 1, 1, 1, 1};  // issue+retire while empty
    vecs[12] = '{0, 0, 1, 1, 1, 1, 1};  // lone retire while empty ignored
    vecs[13] = '{0, 1, 0, 2, 1, 0, 1};  // refill
    vecs[14] = '{0, 1, 0, 3, 1, 0, 1};
    vecs[15] = '{0, 1, 0, 0, 1, 0, 1};  // next wraps 3 -> 0
    vecs[16] = '{0, 1, 0, 1, 1, 0, 0};  // full
    vecs[17] = '{0, 1, 1, 1, 2, 0, 1};  // full: issue dropped, retire kept
    vecs[18] = '{0, 1, 0, 2, 2, 0, 0};  // freed slot usable next cycle
    vecs[19] = '{1, 1, 1, 0, 0, 1, 1};  // reset beats events
    vecs[20] = '{0, 1, 0, 1, 0, 0, 1};  // issue 3 then reset
    vecs[21] = '{0, 1, 0, 2, 0, 0, 1};
    vecs[22] = '{0, 1, 0, 3, 0, 0, 1};
    vecs[23] = '{1, 0, 0, 0, 0, 1, 1};

    rst = 1'b1; issued = 1'b0; retired = 1'b0;
    @(posedge clk);
    #1;

    // Directed table.
    for (int v = 0; v < NVEC; v++) begin
      step(vecs[v].rst, vecs[v].iss, vecs[v].ret);
      $display("vec %0d: rst=%0b iss=%0b ret=%0b -> next=%0d oldest=%0d empty=%0b avail=%0b",
               v, vecs[v].rst, vecs[v].iss, vecs[v].ret, next_id, oldest_id, empty, id_available);
      chk($sformatf("vec%0d.next_id", v),      int'(next_id),      vecs[v].exp_next);
      chk($sformatf("vec%0d.oldest_id", v),    int'(oldest_id),    vecs[v].exp_oldest);
      chk($sformatf("vec%0d.empty", v),        int'(empty),        int'(vecs[v].exp_empty));
      chk($sformatf("vec%0d.id_available", v), int'(id_available), int'(vecs[v].exp_avail));
    end

    // Streaming: one in flight, issue and retire every cycle for 10 cycles.
    step(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, 1'b1);
      $display("stream %0d: next=%0d oldest=%0d empty=%0b avail=%0b",
               k, next_id, oldest_id, empty, id_available);
      chk($sformatf("stream%0d.next_id", k),   int'(next_id),   (1 + k) % MAX);
      chk($sformatf("stream%0d.oldest_id", k), int'(oldest_id), k % MAX);
      chk($sformatf("stream%0d.empty", k),     int'(empty),     0);
      chk($sformatf("stream%0d.avail", k),     int'(id_available), 1);
    end

    // Randomized traffic against the model.
    step(1'b1, 1'b0, 1'b0);
    model_step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 400; c++) begin
      logic r, i, t;
      r = ($urandom_range(0, 49) == 0);
      i = ($urandom_range(0, 99) < 60);
      t = ($urandom_range(0, 99) < 50);
      step(r, i, t);
      model_step(r, i, t);
      $display("rand %0d: rst=%0b iss=%0b ret=%0b -> next=%0d oldest=%0d empty=%0b avail=%0b (model count=%0d)",
               c, r, i, t, next_id, oldest_id, empty, id_available, m_count);
      check_model($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
